// File: rtl/act_row_dispatch.sv
// Activation row dispatcher: deals a single valid/ready activation stream out in
// fixed-length bursts, round-robin across N_ROW per-row FIFOs, under a start/busy/done job.
module act_row_dispatch #(
    parameter int N_ROW      = 7,
    parameter int WID_ACT    = 16,
    parameter int FIFO_DEPTH = 4,
    parameter int WID_BURST  = 8,
    parameter int WID_NBURST = 16
) (
    input  logic                          clk_l,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WID_BURST-1:0]          cfg_burst_len,
    input  logic [WID_NBURST-1:0]         cfg_n_burst,
    input  logic [2*WID_ACT-1:0]          in_data,
    input  logic                          in_vld,
    output logic                          in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]    act_data_in,
    output logic [N_ROW-1:0]              act_data_in_vld,
    input  logic [N_ROW-1:0]              act_data_in_req,
    output logic                          busy,
    output logic                          done,
    output logic [1:0]                    dbg_state_o
);

    localparam int WORD = 2 * WID_ACT;
    localparam int AW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int RW   = (N_ROW > 1) ? $clog2(N_ROW) : 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    // Handshake: a word moves on in_data only in a cycle where in_vld && in_rdy at the
    // rising edge; in_rdy depends on registered state only, never on in_vld or req.
    logic [1:0]            state_q, state_d;
    logic [RW-1:0]         row_ptr_q, row_ptr_d;
    logic [WID_BURST-1:0]  word_cnt_q, word_cnt_d;
    logic [WID_NBURST-1:0] burst_cnt_q, burst_cnt_d;
    logic [WID_BURST-1:0]  len_q, len_d;
    logic [WID_NBURST-1:0] nb_q, nb_d;

    logic [N_ROW-1:0] full;
    logic             accept;

    assign in_rdy      = (state_q == S_RUN) && !full[row_ptr_q];
    assign accept      = in_vld && in_rdy;
    assign busy        = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign done        = (state_q == S_DONE);
    assign dbg_state_o = state_q;

    for (genvar r = 0; r < N_ROW; r++) begin : g_row
        logic [WORD-1:0] mem_q [FIFO_DEPTH];
        logic [AW-1:0]   rd_ptr_q;
        logic [AW-1:0]   wr_ptr_q;
        logic [AW:0]     cnt_q;
        logic            push;
        logic            pop;

        assign push = accept && (row_ptr_q == RW'(r));
        assign pop  = act_data_in_vld[r] && act_data_in_req[r];

        // Storage is reset too so the head reads zero out of reset.
        always_ff @(posedge clk_l or posedge rst) begin
            if (rst) begin
                rd_ptr_q <= '0;
                wr_ptr_q <= '0;
                cnt_q    <= '0;
                for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            end else begin
                if (push) begin
                    mem_q[wr_ptr_q] <= in_data;
                    wr_ptr_q        <= wr_ptr_q + AW'(1);
                end
                if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
                case ({push, pop})
                    2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                    2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                    default: cnt_q <= cnt_q;
                endcase
            end
        end

        assign act_data_in_vld[r]           = (cnt_q != '0);
        assign full[r]                      = (cnt_q == (AW+1)'(FIFO_DEPTH));
        assign act_data_in[r*WORD +: WORD]  = mem_q[rd_ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        row_ptr_d   = row_ptr_q;
        word_cnt_d  = word_cnt_q;
        burst_cnt_d = burst_cnt_q;
        len_d       = len_q;
        nb_d        = nb_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d       = cfg_burst_len;
                    nb_d        = cfg_n_burst;
                    row_ptr_d   = '0;
                    word_cnt_d  = '0;
                    burst_cnt_d = '0;
                    state_d     = (cfg_burst_len != '0 && cfg_n_burst != '0) ? S_RUN : S_DRAIN;
                end
            end
            S_RUN: begin
                if (accept) begin
                    if (word_cnt_q == len_q - WID_BURST'(1)) begin
                        word_cnt_d  = '0;
                        burst_cnt_d = burst_cnt_q + WID_NBURST'(1);
                        row_ptr_d   = (row_ptr_q == RW'(N_ROW-1)) ? '0 : row_ptr_q + RW'(1);
                        if (burst_cnt_q == nb_q - WID_NBURST'(1)) state_d = S_DRAIN;
                    end else begin
                        word_cnt_d = word_cnt_q + WID_BURST'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (act_data_in_vld == '0) state_d = S_DONE;
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_l or posedge rst) begin
        if (rst) begin
            state_q     <= S_IDLE;
            row_ptr_q   <= '0;
            word_cnt_q  <= '0;
            burst_cnt_q <= '0;
            len_q       <= '0;
            nb_q        <= '0;
        end else begin
            state_q     <= state_d;
            row_ptr_q   <= row_ptr_d;
            word_cnt_q  <= word_cnt_d;
            burst_cnt_q <= burst_cnt_d;
            len_q       <= len_d;
            nb_q        <= nb_d;
        end
    end

endmodule

// File: tb/tb_act_row_dispatch.sv
// Directed bench for act_row_dispatch: per-row expected queues filled by the driver,
// drained and compared whenever a row pops its head.
module tb_act_row_dispatch;

    localparam int N = 7;
    localparam int W = 32;

    logic           clk_l = 1'b0;
    logic           rst = 1'b1;
    logic           start = 1'b0;
    logic [7:0]     cfg_burst_len = '0;
    logic [15:0]    cfg_n_burst = '0;
    logic [W-1:0]   in_data = '0;
    logic           in_vld = 1'b0;
    logic           in_rdy;
    logic [W*N-1:0] act_data_in;
    logic [N-1:0]   act_data_in_vld;
    logic [N-1:0]   act_data_in_req = '0;
    logic           busy;
    logic           done;
    logic [1:0]     dbg_state_o;

    act_row_dispatch dut (
        .clk_l           (clk_l),
        .rst             (rst),
        .start           (start),
        .cfg_burst_len   (cfg_burst_len),
        .cfg_n_burst     (cfg_n_burst),
        .in_data         (in_data),
        .in_vld          (in_vld),
        .in_rdy          (in_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req),
        .busy            (busy),
        .done            (done),
        .dbg_state_o     (dbg_state_o)
    );

    always #5 clk_l = ~clk_l;

    logic [W-1:0] exp_q [N][$];
    int checks = 0;
    int errors = 0;
    int done_cnt = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every head consumed by a row must be the next word expected for that row.
    always @(negedge clk_l) begin
        if (!rst) begin
            for (int r = 0; r < N; r++) begin
                if (act_data_in_vld[r] && act_data_in_req[r]) begin
                    logic have;
                    have = (exp_q[r].size() != 0);
                    check($sformatf("row%0d_pop_expected", r), {63'd0, have}, 64'd1);
                    if (have) check($sformatf("row%0d_data", r), {32'd0, act_data_in[r*W +: W]},
                                    {32'd0, exp_q[r].pop_front()});
                end
            end
            if (done) done_cnt++;
        end
    end

    task automatic do_start(input logic [7:0] len, input logic [15:0] nb);
        @(posedge clk_l); #1;
        start = 1'b1; cfg_burst_len = len; cfg_n_burst = nb;
        @(posedge clk_l); #1;
        start = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the word was accepted.
    task automatic send(input logic [W-1:0] w, input int row, output int waits);
        in_data = w;
        in_vld  = 1'b1;
        exp_q[row].push_back(w);
        waits = 0;
        forever begin
            @(negedge clk_l);
            if (in_rdy) break;
            waits++;
            if (waits >= 100) begin
                check("send_timeout", {63'd0, in_rdy}, 64'd1);
                break;
            end
        end
        @(posedge clk_l); #1;
    endtask

    task automatic run_words(input int len, input int nwords, input logic [W-1:0] base,
                             input int start_at);
        int w;
        for (int i = 0; i < nwords; i++) begin
            if (i == start_at) begin
                start = 1'b1; cfg_burst_len = 8'd1; cfg_n_burst = 16'd1;
            end
            send(base + W'(i), (i / len) % N, w);
            start = 1'b0;
            check($sformatf("no_stall_word%0d", i), 64'(w), 64'd0);
        end
        in_vld = 1'b0;
    endtask

    task automatic wait_done(output int n);
        n = 0;
        forever begin
            @(negedge clk_l);
            n++;
            if (done) break;
            if (n >= 60) begin
                check("done_timeout", {63'd0, done}, 64'd1);
                break;
            end
        end
    endtask

    initial begin
        int n;
        int w;
        int snap;

        // Reset values
        repeat (3) @(posedge clk_l);
        @(negedge clk_l);
        check("rst_in_rdy", {63'd0, in_rdy}, 64'd0);
        check("rst_vld", 64'(act_data_in_vld), 64'd0);
        check("rst_data", {32'd0, act_data_in[W-1:0]}, 64'd0);
        check("rst_data_row6", {32'd0, act_data_in[6*W +: W]}, 64'd0);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        @(posedge clk_l); #1;
        rst = 1'b0;

        // Basic: 2 words per row across all 7 rows, full-rate consumption
        act_data_in_req = '1;
        do_start(8'd2, 16'd7);
        check("basic_busy", {63'd0, busy}, 64'd1);
        check("basic_in_rdy", {63'd0, in_rdy}, 64'd1);
        run_words(2, 14, 32'h1, -1);
        wait_done(n);
        // Last accept edge -> done two edges later, i.e. the third negedge after return.
        check("basic_done_latency", 64'(n), 64'd3);
        check("basic_busy_at_done", {63'd0, busy}, 64'd0);
        @(negedge clk_l);
        check("basic_done_pulse", {63'd0, done}, 64'd0);

        // Wrap: one word per burst, 9 bursts
        do_start(8'd1, 16'd9);
        run_words(1, 9, 32'h1, -1);
        wait_done(n);
        check("wrap_done_latency", 64'(n), 64'd3);

        // Backpressure on row 0 with a full FIFO
        act_data_in_req = 7'b1111110;
        do_start(8'd6, 16'd1);
        for (int i = 1; i <= 4; i++) begin
            send(W'(i), 0, w);
            check("bp_fill_no_stall", 64'(w), 64'd0);
        end
        in_data = 32'h5; in_vld = 1'b1;
        exp_q[0].push_back(32'h5);
        repeat (3) begin
            @(negedge clk_l);
            check("bp_hold_low", {63'd0, in_rdy}, 64'd0);
        end
        @(posedge clk_l); #1;
        act_data_in_req[0] = 1'b1;
        @(negedge clk_l);
        check("full_pop_no_push", {63'd0, in_rdy}, 64'd0);
        @(posedge clk_l); #1;
        act_data_in_req[0] = 1'b0;
        @(negedge clk_l);
        check("bp_rdy_after_pop", {63'd0, in_rdy}, 64'd1);
        @(posedge clk_l); #1;
        @(negedge clk_l);
        check("bp_refull", {63'd0, in_rdy}, 64'd0);
        check("bp_row0_vld", {63'd0, act_data_in_vld[0]}, 64'd1);
        @(posedge clk_l); #1;
        act_data_in_req[0] = 1'b1;
        send(32'h6, 0, w);
        in_vld = 1'b0;
        wait_done(n);

        // Zero config: straight to DRAIN, done two cycles after start
        @(posedge clk_l); #1;
        start = 1'b1; cfg_burst_len = 8'd0; cfg_n_burst = 16'd5;
        @(posedge clk_l); #1;
        start = 1'b0;
        @(negedge clk_l);
        check("zero_busy", {63'd0, busy}, 64'd1);
        check("zero_in_rdy", {63'd0, in_rdy}, 64'd0);
        check("zero_not_done_yet", {63'd0, done}, 64'd0);
        @(negedge clk_l);
        check("zero_done", {63'd0, done}, 64'd1);
        check("zero_in_rdy_at_done", {63'd0, in_rdy}, 64'd0);

        // Start while busy: second start (1,1) mid-job must be ignored
        do_start(8'd2, 16'd7);
        run_words(2, 14, 32'h100, 3);
        wait_done(n);
        check("restart_ignored_latency", 64'(n), 64'd3);

        // Reset mid-job, rows hold data
        act_data_in_req = '0;
        do_start(8'd2, 16'd7);
        for (int i = 0; i < 5; i++) send(32'h200 + W'(i), i / 2, w);
        in_vld = 1'b0;
        check("pre_reset_vld", 64'(act_data_in_vld), 64'h7);
        snap = done_cnt;
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 64'(act_data_in_vld), 64'd0);
        check("mid_rst_busy", {63'd0, busy}, 64'd0);
        check("mid_rst_in_rdy", {63'd0, in_rdy}, 64'd0);
        for (int r = 0; r < N; r++) exp_q[r].delete();
        repeat (2) @(posedge clk_l);
        #1;
        rst = 1'b0;
        repeat (2) @(negedge clk_l);
        check("mid_rst_no_done", 64'(done_cnt), 64'(snap));
        act_data_in_req = '1;
        do_start(8'd2, 16'd7);
        run_words(2, 14, 32'h300, -1);
        wait_done(n);
        check("post_rst_done_latency", 64'(n), 64'd3);

        repeat (3) @(negedge clk_l);
        for (int r = 0; r < N; r++)
            check($sformatf("row%0d_queue_empty", r), 64'(exp_q[r].size()), 64'd0);
        check("done_pulse_count", 64'(done_cnt), 64'd6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
